// File: rtl/adder_pkg.sv
// Shared definitions for the 16-bit adder datapath: op codes, flag bit
// positions inside the {N,Z,C,V} nibble, and the default data width.
package adder_pkg;

  localparam int ADDER_W = 16;
  localparam int OP_W    = 3;
  localparam int FLAG_W  = 4;

  // Adder control codes, carried through the result stage uninterpreted
  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_ADDU = 3'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
  localparam logic [OP_W-1:0] OP_SUBU = 3'd3;
  localparam logic [OP_W-1:0] OP_INC  = 3'd4;
  localparam logic [OP_W-1:0] OP_DEC  = 3'd5;

  // Bit positions inside the flag nibble
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // Assemble the flag nibble from its individual bits
  function automatic logic [FLAG_W-1:0] make_flags(input logic n, input logic z,
                                                   input logic c, input logic v);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry register FIFO (skid buffer) with valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and the head stays stable while
// o_valid && !o_ready. i_ready is decoded from registered occupancy only.
module result_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data
);

  logic [1:0]    r_count;
  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;
  logic          w_push;
  logic          w_pop;

  assign i_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head;
  assign w_push  = i_valid && i_ready;
  assign w_pop   = o_valid && o_ready;

  // Occupancy and storage update; head register drives the output directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head  <= i_data;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head <= i_data;
          end else if (w_push) begin
            r_tail  <= i_data;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          // Full: no push possible, a pop promotes the tail
          if (w_pop) begin
            r_head  <= r_tail;
            r_count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/adder_result_stage.sv
// Registered output stage behind the adder: computes {N,Z,C,V}, buffers
// {op, flags, result} in a 2-entry FIFO and, when ADDER_RESULT_STAGE_STICKY_EN
// is defined, keeps sticky C/V bits and a saturating overflow-event counter.
module adder_result_stage
  import adder_pkg::*;
#(
  parameter int W     = ADDER_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_result,
  input  logic             in_over,
  input  logic             in_cout,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [OP_W-1:0]  out_op,
  output logic [FLAG_W-1:0] out_flags,
  input  logic             clr_sticky,
  output logic [1:0]       sticky_flags,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int PW = OP_W + FLAG_W + W;

  logic [FLAG_W-1:0] w_flags;
  logic [PW-1:0]     w_in_payload;
  logic [PW-1:0]     w_out_payload;
  logic              w_push;

  assign w_flags      = make_flags(in_result[W-1], (in_result == '0), in_cout, in_over);
  assign w_in_payload = {in_op, w_flags, in_result};
  assign w_push       = in_valid && in_ready;

  result_fifo2 #(.DW(PW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .i_ready (in_ready),
    .i_data  (w_in_payload),
    .o_valid (out_valid),
    .o_ready (out_ready),
    .o_data  (w_out_payload)
  );

  assign out_result = w_out_payload[W-1:0];
  assign out_flags  = w_out_payload[W +: FLAG_W];
  assign out_op     = w_out_payload[W+FLAG_W +: OP_W];

`ifdef ADDER_RESULT_STAGE_STICKY_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             r_sticky_c;
  logic             r_sticky_v;
  logic [CNT_W-1:0] r_ovf_count;
  logic             w_push_v;

  assign w_push_v = w_push && in_over;

  // Sticky accumulation; a clear in the same cycle as a flagged push keeps the push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_c  <= 1'b0;
      r_sticky_v  <= 1'b0;
      r_ovf_count <= '0;
    end else if (clr_sticky) begin
      r_sticky_c  <= w_push && in_cout;
      r_sticky_v  <= w_push_v;
      r_ovf_count <= w_push_v ? CNT_W'(1) : '0;
    end else begin
      r_sticky_c <= r_sticky_c | (w_push && in_cout);
      r_sticky_v <= r_sticky_v | w_push_v;
      if (w_push_v && (r_ovf_count != CNT_MAX)) begin
        r_ovf_count <= r_ovf_count + CNT_W'(1);
      end
    end
  end

  assign sticky_flags = {r_sticky_c, r_sticky_v};
  assign ovf_count    = r_ovf_count;
`else
  logic w_unused;

  assign w_unused     = clr_sticky;
  assign sticky_flags = 2'b00;
  assign ovf_count    = '0;
`endif

endmodule

// File: tb/tb_adder_result_stage.sv
// Directed bench for adder_result_stage. Sticky/counter expectations follow
// ADDER_RESULT_STAGE_STICKY_EN; without it they are expected to stay 0.
module tb_adder_result_stage;
  import adder_pkg::*;

  localparam int W     = 16;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_result;
  logic             in_over;
  logic             in_cout;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic [2:0]       out_op;
  logic [3:0]       out_flags;
  logic             clr_sticky;
  logic [1:0]       sticky_flags;
  logic [CNT_W-1:0] ovf_count;

  int n_vec;
  int n_err;

  // sticky model
  logic m_sc;
  logic m_sv;
  int   m_cnt;

  // scoreboard of {op, result}
  logic [W+2:0] exp_q[$];
  logic [W+2:0] exp_item;

  adder_result_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_over      (in_over),
    .in_cout      (in_cout),
    .in_op        (in_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_op       (out_op),
    .out_flags    (out_flags),
    .clr_sticky   (clr_sticky),
    .sticky_flags (sticky_flags),
    .ovf_count    (ovf_count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_sc  = 1'b0;
    m_sv  = 1'b0;
    m_cnt = 0;
  endtask

  // Advance one clock; exp_push says whether the bench expects a push this edge
  task automatic tick(input bit exp_push);
`ifdef ADDER_RESULT_STAGE_STICKY_EN
    if (clr_sticky) begin
      m_sc  = exp_push && in_cout;
      m_sv  = exp_push && in_over;
      m_cnt = (exp_push && in_over) ? 1 : 0;
    end else if (exp_push) begin
      m_sc = m_sc | in_cout;
      m_sv = m_sv | in_over;
      if (in_over && m_cnt != CMAX) m_cnt++;
    end
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] r, input logic o,
                       input logic c, input logic [2:0] op);
    in_valid  = v;
    in_result = r;
    in_over   = o;
    in_cout   = c;
    in_op     = op;
  endtask

  task automatic check_sticky(input string tag);
    check({tag, "_sticky"}, {30'd0, sticky_flags}, {30'd0, m_sc, m_sv});
    check({tag, "_ovf"}, {24'd0, ovf_count}, m_cnt);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, OP_ADD);
    model_clear();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_op", out_op, 0);
    check("rst_out_flags", out_flags, 0);
    check_sticky("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // single zero result with carry, consumer ready
    out_ready = 1'b1;
    drive(1'b1, 16'h0000, 1'b0, 1'b1, OP_ADDU);
    tick(1);
    drive(1'b0, '0, 1'b0, 1'b0, OP_ADD);
    check("t1_valid", out_valid, 1);
    check("t1_result", out_result, 16'h0000);
    check("t1_flags", out_flags, 4'b0110);
    check("t1_op", out_op, OP_ADDU);
    check_sticky("t1");
    tick(0);
    check("t1_empty", out_valid, 0);

    // stalled consumer fills both entries, third push refused
    out_ready = 1'b0;
    drive(1'b1, 16'h8000, 1'b0, 1'b0, OP_SUB);
    tick(1);
    check("t2_ready1", in_ready, 1);
    check("t2_head1", out_result, 16'h8000);
    drive(1'b1, 16'h0001, 1'b0, 1'b0, OP_ADD);
    tick(1);
    check("t2_ready_full", in_ready, 0);
    check("t2_head_stable", out_result, 16'h8000);
    drive(1'b1, 16'h1234, 1'b1, 1'b1, OP_INC);
    tick(0);
    check("t2_still_full", in_ready, 0);
    check("t2_head_flags", out_flags, 4'b1000);
    check("t2_head_op", out_op, OP_SUB);
    check_sticky("t2");
    drive(1'b0, '0, 1'b0, 1'b0, OP_ADD);
    out_ready = 1'b1;
    tick(0);
    check("t2_second_valid", out_valid, 1);
    check("t2_second", out_result, 16'h0001);
    check("t2_second_flags", out_flags, 4'b0000);
    tick(0);
    check("t2_no_third", out_valid, 0);

    // occupancy 1 with push+pop on 16 consecutive cycles
    drive(1'b1, 16'hA5A5, 1'b0, 1'b0, OP_DEC);
    exp_q.push_back({OP_DEC, 16'hA5A5});
    tick(1);
    for (int i = 0; i < 16; i++) begin
      check("t3_ready", in_ready, 1);
      check("t3_valid", out_valid, 1);
      exp_item = exp_q.pop_front();
      check("t3_order", {13'd0, out_op, out_result}, {13'd0, exp_item});
      drive(1'b1, 16'h1000 + W'(i) * 16'h0111, i[0], i[1], 3'(i % 6));
      exp_q.push_back({3'(i % 6), in_result});
      tick(1);
    end
    drive(1'b0, '0, 1'b0, 1'b0, OP_ADD);
    exp_item = exp_q.pop_front();
    check("t3_last", {13'd0, out_op, out_result}, {13'd0, exp_item});
    check_sticky("t3");
    tick(0);
    check("t3_drained", out_valid, 0);

    // 300 overflow pushes saturate the counter
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0, OP_ADD);
      tick(1);
    end
    drive(1'b0, '0, 1'b0, 1'b0, OP_ADD);
    check_sticky("t4_sat");
    tick(0);
    // clear together with a V=1, C=0 push: set wins
    clr_sticky = 1'b1;
    drive(1'b1, 16'h7FFF, 1'b1, 1'b0, OP_ADD);
    tick(1);
    clr_sticky = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, OP_ADD);
    check_sticky("t4_clr_push");
    check("t4_flags", out_flags, 4'b0001);
    tick(0);
    // clear alone
    clr_sticky = 1'b1;
    tick(0);
    clr_sticky = 1'b0;
    check_sticky("t4_clr");

    // reset while two entries are held
    out_ready = 1'b0;
    drive(1'b1, 16'h0F0F, 1'b1, 1'b1, OP_SUBU);
    tick(1);
    drive(1'b1, 16'hF0F0, 1'b1, 1'b0, OP_ADD);
    tick(1);
    drive(1'b0, '0, 1'b0, 1'b0, OP_ADD);
    check("t5_full", in_ready, 0);
    check_sticky("t5_pre");
    rst_n = 1'b0;
    #1;
    model_clear();
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_ready", in_ready, 1);
    check("t5_rst_result", out_result, 0);
    check_sticky("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 16'hFFFF, 1'b0, 1'b1, OP_DEC);
    tick(1);
    drive(1'b0, '0, 1'b0, 1'b0, OP_ADD);
    check("t5_first_valid", out_valid, 1);
    check("t5_first_result", out_result, 16'hFFFF);
    check("t5_first_flags", out_flags, 4'b1010);
    check_sticky("t5_post");
    tick(0);
    check("t5_empty", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
